// File: rtl/pll_cfg_writer.sv
//------------------------------------------------------------------------------
// pll_cfg_writer: Avalon-MM write sequencer that reprograms a PLL reconfig
// block and then waits for a confirmed lock or a lock timeout.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module pll_cfg_writer #(
  parameter int unsigned LOCK_TIMEOUT = 65535,
  parameter int unsigned LOCK_STABLE  = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cfg_req,
  input  logic [17:0] cfg_n,
  input  logic [17:0] cfg_m,
  input  logic [17:0] cfg_c0,
  input  logic [17:0] cfg_c1,
  input  logic [31:0] cfg_k,
  input  logic        cfg_k_en,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [5:0]  mgmt_address,
  output logic        mgmt_write,
  output logic [31:0] mgmt_writedata,
  input  logic        mgmt_waitrequest,
  input  logic        pll_locked
);

  localparam int unsigned STB_W    = (LOCK_STABLE > 1) ? $clog2(LOCK_STABLE + 1) : 1;
  localparam logic [16:0] TMO_LAST = 17'(LOCK_TIMEOUT - 1);
  localparam logic [STB_W-1:0] STB_LAST = STB_W'(LOCK_STABLE - 1);

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    MODE      = 4'd1,
    WR_N      = 4'd2,
    WR_M      = 4'd3,
    WR_K      = 4'd4,
    WR_C0     = 4'd5,
    WR_C1     = 4'd6,
    START     = 4'd7,
    SETTLE    = 4'd8,
    LOCK_WAIT = 4'd9,
    DONE      = 4'd10
  } state_t;

  state_t           state_q, state_d;
  logic [17:0]      n_q, n_d, m_q, m_d, c0_q, c0_d, c1_q, c1_d;
  logic [31:0]      k_q, k_d;
  logic             k_en_q, k_en_d;
  logic             busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic             mgmt_write_q, mgmt_write_d;
  logic [5:0]       mgmt_address_q, mgmt_address_d;
  logic [31:0]      mgmt_writedata_q, mgmt_writedata_d;
  logic [16:0]      tmo_q, tmo_d;
  logic [3:0]       settle_q, settle_d;
  logic [STB_W-1:0] stable_q, stable_d;
  logic             xfer;
  logic [16:0]      tmo_inc;

  assign xfer    = mgmt_write_q & ~mgmt_waitrequest;
  assign tmo_inc = (tmo_q == 17'h1FFFF) ? tmo_q : tmo_q + 17'd1;

  always_comb begin
    state_d  = state_q;
    n_d      = n_q;
    m_d      = m_q;
    c0_d     = c0_q;
    c1_d     = c1_q;
    k_d      = k_q;
    k_en_d   = k_en_q;
    err_d    = err_q;
    tmo_d    = tmo_q;
    settle_d = settle_q;
    stable_d = stable_q;

    case (state_q)
      IDLE: begin
        if (cfg_req) begin
          n_d     = cfg_n;
          m_d     = cfg_m;
          c0_d    = cfg_c0;
          c1_d    = cfg_c1;
          k_d     = cfg_k;
          k_en_d  = cfg_k_en;
          err_d   = 1'b0;
          state_d = MODE;
        end
      end
      MODE:  if (xfer) state_d = WR_N;
      WR_N:  if (xfer) state_d = WR_M;
      WR_M:  if (xfer) state_d = k_en_q ? WR_K : WR_C0;
      WR_K:  if (xfer) state_d = WR_C0;
      WR_C0: if (xfer) state_d = WR_C1;
      WR_C1: if (xfer) state_d = START;
      START: begin
        if (xfer) begin
          state_d  = SETTLE;
          tmo_d    = '0;
          settle_d = '0;
          stable_d = '0;
        end
      end
      SETTLE: begin
        tmo_d = tmo_inc;
        if (tmo_q >= TMO_LAST) begin
          state_d = DONE;
          err_d   = 1'b1;
        end else if (settle_q == 4'd15) begin
          state_d = LOCK_WAIT;
        end else begin
          settle_d = settle_q + 4'd1;
        end
      end
      LOCK_WAIT: begin
        tmo_d    = tmo_inc;
        stable_d = pll_locked ? stable_q + 1'b1 : '0;
        // A lock confirmation in the same cycle as the timeout takes priority.
        if (pll_locked && (stable_q == STB_LAST)) begin
          state_d = DONE;
          err_d   = 1'b0;
        end else if (tmo_q >= TMO_LAST) begin
          state_d = DONE;
          err_d   = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Bus outputs are registered from the next state so they line up with it.
    mgmt_write_d     = 1'b1;
    mgmt_address_d   = 6'h00;
    mgmt_writedata_d = 32'h0;
    case (state_d)
      MODE:  ;
      WR_N:  begin mgmt_address_d = 6'h03; mgmt_writedata_d = {14'b0, n_d}; end
      WR_M:  begin mgmt_address_d = 6'h04; mgmt_writedata_d = {14'b0, m_d}; end
      WR_K:  begin mgmt_address_d = 6'h07; mgmt_writedata_d = k_d; end
      WR_C0: begin mgmt_address_d = 6'h05; mgmt_writedata_d = {9'b0, 5'd0, c0_d}; end
      WR_C1: begin mgmt_address_d = 6'h05; mgmt_writedata_d = {9'b0, 5'd1, c1_d}; end
      START: mgmt_address_d = 6'h02;
      default: mgmt_write_d = 1'b0;
    endcase

    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q          <= IDLE;
      n_q              <= '0;
      m_q              <= '0;
      c0_q             <= '0;
      c1_q             <= '0;
      k_q              <= '0;
      k_en_q           <= 1'b0;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
      err_q            <= 1'b0;
      mgmt_write_q     <= 1'b0;
      mgmt_address_q   <= '0;
      mgmt_writedata_q <= '0;
      tmo_q            <= '0;
      settle_q         <= '0;
      stable_q         <= '0;
    end else begin
      state_q          <= state_d;
      n_q              <= n_d;
      m_q              <= m_d;
      c0_q             <= c0_d;
      c1_q             <= c1_d;
      k_q              <= k_d;
      k_en_q           <= k_en_d;
      busy_q           <= busy_d;
      done_q           <= done_d;
      err_q            <= err_d;
      mgmt_write_q     <= mgmt_write_d;
      mgmt_address_q   <= mgmt_address_d;
      mgmt_writedata_q <= mgmt_writedata_d;
      tmo_q            <= tmo_d;
      settle_q         <= settle_d;
      stable_q         <= stable_d;
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign err            = err_q;
  assign mgmt_write     = mgmt_write_q;
  assign mgmt_address   = mgmt_address_q;
  assign mgmt_writedata = mgmt_writedata_q;

endmodule

`default_nettype wire

// File: tb/tb_pll_cfg_writer.sv
//------------------------------------------------------------------------------
// tb_pll_cfg_writer: table-driven bench with a write scoreboard for pll_cfg_writer.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_pll_cfg_writer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_req = 1'b0;
  logic [17:0] cfg_n = '0, cfg_m = '0, cfg_c0 = '0, cfg_c1 = '0;
  logic [31:0] cfg_k = '0;
  logic        cfg_k_en = 1'b0;
  logic        busy, done, err;
  logic [5:0]  mgmt_address;
  logic        mgmt_write;
  logic [31:0] mgmt_writedata;
  logic        mgmt_waitrequest = 1'b0;
  logic        pll_locked = 1'b0;

  pll_cfg_writer #(.LOCK_TIMEOUT(100), .LOCK_STABLE(4)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .cfg_req          (cfg_req),
    .cfg_n            (cfg_n),
    .cfg_m            (cfg_m),
    .cfg_c0           (cfg_c0),
    .cfg_c1           (cfg_c1),
    .cfg_k            (cfg_k),
    .cfg_k_en         (cfg_k_en),
    .busy             (busy),
    .done             (done),
    .err              (err),
    .mgmt_address     (mgmt_address),
    .mgmt_write       (mgmt_write),
    .mgmt_writedata   (mgmt_writedata),
    .mgmt_waitrequest (mgmt_waitrequest),
    .pll_locked       (pll_locked)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [17:0] n, m, c0, c1;
    logic [31:0] k;
    logic        k_en;
    int          lock_mode;   // 0 steady high, 1 never, 2 toggle pattern
    int          stall_m;
    logic        exp_err;
    int          exp_lat;     // cycles from SETTLE entry to done
    int          exp_writes;
  } vec_t;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          settle_cyc = 1 << 30;
  int          lock_mode = 0;
  int          stall_left = 0;
  logic [5:0]  stall_addr = 6'h04;
  int          m_cycles = 0;
  int          writes = 0;
  logic [37:0] exp_q[$];
  logic        hold_v = 1'b0;
  logic [5:0]  hold_a;
  logic [31:0] hold_d;
  logic [7:0]  lock_pat = 8'b1111_0111;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Input driver: waitrequest stalls and the pll_locked pattern.
  initial begin
    int rel;
    forever begin
      @(posedge clk);
      #1;
      if (stall_left > 0 && mgmt_write && mgmt_address == stall_addr) begin
        mgmt_waitrequest = 1'b1;
        stall_left--;
      end else begin
        mgmt_waitrequest = 1'b0;
      end
      rel = cyc - settle_cyc;
      case (lock_mode)
        0: pll_locked = 1'b1;
        1: pll_locked = 1'b0;
        default: pll_locked = (rel >= 16 && rel < 24) ? lock_pat[rel - 16] : 1'b1;
      endcase
    end
  end

  // Bus monitor: scoreboard pop on each completed transfer, stability under stall.
  always @(negedge clk) begin
    logic [37:0] e;
    if (!rst_n) begin
      hold_v = 1'b0;
    end else if (mgmt_write) begin
      if (hold_v) begin
        check("hold_addr", 64'(mgmt_address), 64'(hold_a));
        check("hold_data", 64'(mgmt_writedata), 64'(hold_d));
      end
      if (mgmt_address == 6'h04) m_cycles++;
      if (!mgmt_waitrequest) begin
        writes++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write", mgmt_address, mgmt_writedata);
        end else begin
          e = exp_q.pop_front();
          check("wr_addr", 64'(mgmt_address), 64'(e[37:32]));
          check("wr_data", 64'(mgmt_writedata), 64'(e[31:0]));
        end
        if (mgmt_address == 6'h02) settle_cyc = cyc + 1;
        hold_v = 1'b0;
      end else begin
        hold_v = 1'b1;
        hold_a = mgmt_address;
        hold_d = mgmt_writedata;
      end
    end else begin
      hold_v = 1'b0;
    end
  end

  function automatic void push_exp(vec_t v);
    exp_q.push_back({6'h00, 32'h0});
    exp_q.push_back({6'h03, 14'b0, v.n});
    exp_q.push_back({6'h04, 14'b0, v.m});
    if (v.k_en) exp_q.push_back({6'h07, v.k});
    exp_q.push_back({6'h05, 9'b0, 5'd0, v.c0});
    exp_q.push_back({6'h05, 9'b0, 5'd1, v.c1});
    exp_q.push_back({6'h02, 32'h0});
  endfunction

  task automatic run_vec(input vec_t v);
    bit got;
    lock_mode  = v.lock_mode;
    stall_addr = 6'h04;
    stall_left = v.stall_m;
    m_cycles   = 0;
    writes     = 0;
    settle_cyc = 1 << 30;
    push_exp(v);
    @(posedge clk); #1;
    cfg_n = v.n; cfg_m = v.m; cfg_c0 = v.c0; cfg_c1 = v.c1; cfg_k = v.k; cfg_k_en = v.k_en;
    cfg_req = 1'b1;
    @(posedge clk); #1;
    check("busy_after_accept", 64'(busy), 64'(1));
    check("err_cleared", 64'(err), 64'(0));
    // Scramble inputs and keep requesting while the sequence is active.
    for (int i = 0; i < 20; i++) begin
      cfg_n = 18'($urandom); cfg_m = 18'($urandom); cfg_c0 = 18'($urandom);
      cfg_c1 = 18'($urandom); cfg_k = $urandom; cfg_k_en = 1'($urandom);
      cfg_req = 1'b1;
      @(posedge clk); #1;
    end
    cfg_req = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 400 && !got; i++) begin
      if (done) got = 1'b1;
      else begin @(posedge clk); #1; end
    end
    check("done_seen", 64'(got), 64'(1));
    if (got) begin
      check("done_latency", 64'(cyc - settle_cyc), 64'(v.exp_lat));
      check("err_at_done", 64'(err), 64'(v.exp_err));
      check("scoreboard_empty", 64'(exp_q.size()), 64'(0));
      check("write_count", 64'(writes), 64'(v.exp_writes));
      check("m_write_cycles", 64'(m_cycles), 64'(v.stall_m + 1));
      @(posedge clk); #1;
      check("busy_after_done", 64'(busy), 64'(0));
      check("done_one_cycle", 64'(done), 64'(0));
      check("err_held", 64'(err), 64'(v.exp_err));
      repeat (5) @(posedge clk);
      #1;
      check("no_restart", 64'(busy), 64'(0));
    end
    exp_q.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[5];
    bit   got;
    int   act_cnt;
    vecs[0] = '{n:18'h10000, m:18'h00808, c0:18'h00505, c1:18'h20202, k:32'h80000000, k_en:1'b1,
                lock_mode:0, stall_m:0, exp_err:1'b0, exp_lat:20, exp_writes:7};
    vecs[1] = '{n:18'h00101, m:18'h3FFFF, c0:18'h3FFFF, c1:18'h00000, k:32'h12345678, k_en:1'b0,
                lock_mode:0, stall_m:0, exp_err:1'b0, exp_lat:20, exp_writes:6};
    vecs[2] = '{n:18'h2AAAA, m:18'h15555, c0:18'h00001, c1:18'h3FFFE, k:32'hDEADBEEF, k_en:1'b1,
                lock_mode:0, stall_m:5, exp_err:1'b0, exp_lat:20, exp_writes:7};
    vecs[3] = '{n:18'h00003, m:18'h00004, c0:18'h00005, c1:18'h00006, k:32'h0, k_en:1'b0,
                lock_mode:1, stall_m:0, exp_err:1'b1, exp_lat:100, exp_writes:6};
    vecs[4] = '{n:18'h12345, m:18'h0ABCD, c0:18'h01111, c1:18'h02222, k:32'hCAFEF00D, k_en:1'b1,
                lock_mode:2, stall_m:0, exp_err:1'b0, exp_lat:24, exp_writes:7};

    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_err", 64'(err), 64'(0));
    check("rst_write", 64'(mgmt_write), 64'(0));
    check("rst_addr", 64'(mgmt_address), 64'(0));
    check("rst_data", 64'(mgmt_writedata), 64'(0));
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    // Reset while the C0 write is stalled.
    lock_mode  = 0;
    stall_addr = 6'h05;
    stall_left = 1000;
    exp_q.push_back({6'h00, 32'h0});
    exp_q.push_back({6'h03, 14'b0, vecs[1].n});
    exp_q.push_back({6'h04, 14'b0, vecs[1].m});
    @(posedge clk); #1;
    cfg_n = vecs[1].n; cfg_m = vecs[1].m; cfg_c0 = vecs[1].c0; cfg_c1 = vecs[1].c1;
    cfg_k = vecs[1].k; cfg_k_en = 1'b0; cfg_req = 1'b1;
    @(posedge clk); #1;
    cfg_req = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 60 && !got; i++) begin
      if (mgmt_write && mgmt_address == 6'h05 && mgmt_waitrequest) got = 1'b1;
      else begin @(posedge clk); #1; end
    end
    check("c0_stall_reached", 64'(got), 64'(1));
    repeat (2) @(posedge clk);
    #1;
    check("c0_prior_writes", 64'(exp_q.size()), 64'(0));
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("rst_mid_write", 64'(mgmt_write), 64'(0));
    check("rst_mid_busy", 64'(busy), 64'(0));
    rst_n = 1'b1;
    stall_left = 0;
    exp_q.delete();
    act_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (mgmt_write || busy) act_cnt++;
    end
    check("no_reissue_after_rst", 64'(act_cnt), 64'(0));

    run_vec(vecs[0]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
